// File: rtl/pu_outbuf_arbiter_pkg.sv
// Shared types and sizing helpers for the PU output-buffer arbiter.
package pu_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Burst counter must hold the value 16.
    localparam int BURST_CNT_W = 5;

    function automatic int pu_id_w(input int num_pu);
        return (num_pu > 1) ? $clog2(num_pu) : 1;
    endfunction

endpackage

// File: rtl/pu_outbuf_arbiter_if.sv
// PU request streams plus the shared outbuf push port.
interface pu_outbuf_arbiter_if
    import pu_arb_pkg::*;
#(
    parameter int NUM_PU    = 4,
    parameter int PU_DATA_W = 16
);
    localparam int PU_ID_W = pu_id_w(NUM_PU);

    logic [NUM_PU-1:0]           req_valid;
    logic [NUM_PU-1:0]           req_last;
    logic [NUM_PU*PU_DATA_W-1:0] req_data;
    logic [NUM_PU-1:0]           req_ready;
    logic                        outbuf_push;
    logic [PU_DATA_W-1:0]        outbuf_data_in;
    logic [PU_ID_W-1:0]          outbuf_pu_id;
    logic                        outbuf_full;

    modport master (
        input  req_valid, req_last, req_data, outbuf_full,
        output req_ready, outbuf_push, outbuf_data_in, outbuf_pu_id
    );

    modport slave (
        output req_valid, req_last, req_data, outbuf_full,
        input  req_ready, outbuf_push, outbuf_data_in, outbuf_pu_id
    );

endinterface

// File: rtl/pu_outbuf_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or above ptr, wrapping.
module rr_pick
    import pu_arb_pkg::*;
#(
    parameter int NUM_PU = 4,
    localparam int PU_ID_W = pu_id_w(NUM_PU)
) (
    input  logic [NUM_PU-1:0]  req,
    input  logic [PU_ID_W-1:0] ptr,
    output logic               found,
    output logic [PU_ID_W-1:0] pick
);

    logic [PU_ID_W:0] idx;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_PU; k++) begin
            idx = {1'b0, ptr} + (PU_ID_W+1)'(k);
            if (idx >= (PU_ID_W+1)'(NUM_PU)) begin
                idx = idx - (PU_ID_W+1)'(NUM_PU);
            end
            if (!found && req[idx[PU_ID_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[PU_ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pu_outbuf_arbiter.sv
// Round-robin burst arbiter sharing the outbuf push path between NUM_PU result streams.
// Define PU_ARB_STATS_EN to add per-PU beat counters and a full-stall counter.
//
// state | meaning
// IDLE  | no grant; picks next requester (skipped for one bubble cycle after a release)
// GRANT | one PU owns the push path until BURST_LEN beats or req_last
module pu_outbuf_arbiter
    import pu_arb_pkg::*;
#(
    parameter int NUM_PU    = 4,
    parameter int PU_DATA_W = 16,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    pu_outbuf_arbiter_if.master     bus,
    output logic [NUM_PU-1:0]       grant,
    output logic                    busy,
    output logic [CNT_W-1:0]        beat_count
`ifdef PU_ARB_STATS_EN
    ,
    output logic [NUM_PU*CNT_W-1:0] pu_beat_count,
    output logic [CNT_W-1:0]        stall_count
`endif
);

    localparam int PU_ID_W = pu_id_w(NUM_PU);
    localparam logic [BURST_CNT_W-1:0] LAST_BEAT = BURST_CNT_W'(BURST_LEN - 1);

    arb_state_t               state_q, state_d;
    logic [NUM_PU-1:0]        grant_q;
    logic [PU_ID_W-1:0]       pu_id_q;
    logic [PU_ID_W-1:0]       rr_ptr_q;
    logic [BURST_CNT_W-1:0]   burst_cnt_q;
    logic [CNT_W-1:0]         beat_cnt_q;
    logic                     bubble_q;

    logic                     pick_found;
    logic [PU_ID_W-1:0]       pick_id;
    logic                     g_valid;
    logic                     g_last;
    logic                     push_w;
    logic                     rel_w;
    logic [NUM_PU-1:0]        ready_w;
    logic [PU_DATA_W-1:0]     data_w;

    rr_pick #(
        .NUM_PU (NUM_PU)
    ) u_rr_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .pick  (pick_id)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        push_w  = 1'b0;
        rel_w   = 1'b0;
        ready_w = '0;
        data_w  = '0;
        g_valid = bus.req_valid[pu_id_q];
        g_last  = bus.req_last[pu_id_q];
        case (state_q)
            IDLE: begin
                if (!bubble_q && pick_found) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                for (int i = 0; i < NUM_PU; i++) begin
                    if (pu_id_q == PU_ID_W'(i)) begin
                        data_w = bus.req_data[i*PU_DATA_W +: PU_DATA_W];
                    end
                end
                ready_w[pu_id_q] = ~bus.outbuf_full;
                push_w           = g_valid & ~bus.outbuf_full;
                rel_w            = push_w & (g_last | (burst_cnt_q == LAST_BEAT));
                if (rel_w) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // bubble_q holds off arbitration for the cycle right after a release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q     <= '0;
            pu_id_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            beat_cnt_q  <= '0;
            bubble_q    <= 1'b0;
        end else begin
            bubble_q <= rel_w;
            if (state_q == IDLE && state_d == GRANT) begin
                grant_q     <= NUM_PU'(1) << pick_id;
                pu_id_q     <= pick_id;
                burst_cnt_q <= '0;
            end
            if (push_w) begin
                burst_cnt_q <= burst_cnt_q + BURST_CNT_W'(1);
                beat_cnt_q  <= beat_cnt_q + CNT_W'(1);
            end
            if (rel_w) begin
                grant_q  <= '0;
                rr_ptr_q <= (pu_id_q == PU_ID_W'(NUM_PU - 1)) ? '0 : pu_id_q + PU_ID_W'(1);
            end
        end
    end

`ifdef PU_ARB_STATS_EN
    logic [NUM_PU*CNT_W-1:0] pu_cnt_q;
    logic [CNT_W-1:0]        stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pu_cnt_q <= '0;
            stall_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_PU; i++) begin
                if (push_w && pu_id_q == PU_ID_W'(i)) begin
                    pu_cnt_q[i*CNT_W +: CNT_W] <= pu_cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
            if (state_q == GRANT && g_valid && bus.outbuf_full) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign pu_beat_count = pu_cnt_q;
    assign stall_count   = stall_q;
`endif

    assign bus.req_ready      = ready_w;
    assign bus.outbuf_push    = push_w;
    assign bus.outbuf_data_in = data_w;
    assign bus.outbuf_pu_id   = pu_id_q;
    assign grant              = grant_q;
    assign busy               = (state_q == GRANT);
    assign beat_count         = beat_cnt_q;

endmodule

// File: tb/tb_pu_outbuf_arbiter.sv
// Directed bench for pu_outbuf_arbiter: one BURST_LEN=16 instance and one BURST_LEN=4 instance.
module tb_pu_outbuf_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pu_outbuf_arbiter_if #(.NUM_PU(4), .PU_DATA_W(16)) b16 ();
    pu_outbuf_arbiter_if #(.NUM_PU(4), .PU_DATA_W(16)) b4 ();

    logic [3:0]  grant16, grant4;
    logic        busy16, busy4;
    logic [31:0] bc16, bc4;
`ifdef PU_ARB_STATS_EN
    logic [127:0] pbc16, pbc4;
    logic [31:0]  stall16, stall4;
`endif

    pu_outbuf_arbiter #(.NUM_PU(4), .PU_DATA_W(16), .BURST_LEN(16), .CNT_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (b16),
        .grant         (grant16),
        .busy          (busy16),
        .beat_count    (bc16)
`ifdef PU_ARB_STATS_EN
        ,
        .pu_beat_count (pbc16),
        .stall_count   (stall16)
`endif
    );

    pu_outbuf_arbiter #(.NUM_PU(4), .PU_DATA_W(16), .BURST_LEN(4), .CNT_W(32)) dut4 (
        .clk           (clk),
        .reset         (reset),
        .bus           (b4),
        .grant         (grant4),
        .busy          (busy4),
        .beat_count    (bc4)
`ifdef PU_ARB_STATS_EN
        ,
        .pu_beat_count (pbc4),
        .stall_count   (stall4)
`endif
    );

    int n_chk = 0;
    int n_bad = 0;

    int src_cnt[4];
    int src_total[4];
    int src_last[4];
    bit use4;
    logic full;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        logic [3:0]  v, l;
        logic [63:0] d;
        for (int i = 0; i < 4; i++) begin
            v[i]          = (src_cnt[i] < src_total[i]);
            l[i]          = (src_cnt[i] == src_last[i]);
            d[i*16 +: 16] = 16'((i << 12) | src_cnt[i]);
        end
        b16.req_valid = v;  b16.req_last = l;  b16.req_data = d;  b16.outbuf_full = full;
        b4.req_valid  = v;  b4.req_last  = l;  b4.req_data  = d;  b4.outbuf_full  = full;
    endtask

    // Sources advance on beats the selected instance accepted in the cycle just checked.
    task automatic step();
        logic [3:0] acc;
        acc = use4 ? (b4.req_ready & b4.req_valid) : (b16.req_ready & b16.req_valid);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) src_cnt[i]++;
        end
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        full  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src_cnt[i]   = 0;
            src_total[i] = 0;
            src_last[i]  = -1;
        end
        drive();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic check_cycle(input string tag, input int c, input bit ep, input int id, input int data);
        logic       push;
        logic [1:0] pid;
        logic [15:0] dat;
        logic [3:0] gnt;
        push = use4 ? b4.outbuf_push : b16.outbuf_push;
        pid  = use4 ? b4.outbuf_pu_id : b16.outbuf_pu_id;
        dat  = use4 ? b4.outbuf_data_in : b16.outbuf_data_in;
        gnt  = use4 ? grant4 : grant16;
        check_val($sformatf("%s_push_c%0d", tag, c), 64'(push), 64'(ep));
        if (ep) begin
            check_val($sformatf("%s_id_c%0d", tag, c), 64'(pid), 64'(id));
            check_val($sformatf("%s_data_c%0d", tag, c), 64'(dat), 64'(data));
            check_val($sformatf("%s_grant_c%0d", tag, c), 64'(gnt), 64'(1 << id));
        end
    endtask

    initial begin
        int ep, beat, k, id;

        // Single requester, 20 beats, BURST_LEN=16
        use4 = 1'b0;
        do_reset();
        src_total[1] = 20;
        drive();
        for (int c = 0; c <= 24; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check_val("rst_grant", 64'(grant16), 64'h0);
                check_val("rst_busy", 64'(busy16), 64'h0);
                check_val("rst_beats", 64'(bc16), 64'h0);
                check_val("rst_ready", 64'(b16.req_ready), 64'h0);
                check_val("rst_pu_id", 64'(b16.outbuf_pu_id), 64'h0);
            end
            ep   = ((c >= 1 && c <= 16) || (c >= 19 && c <= 22)) ? 1 : 0;
            beat = (c <= 16) ? c - 1 : c - 3;
            check_cycle("t1", c, ep[0], 1, 16'h1000 + beat);
            if (c == 17) begin
                check_val("t1_bubble_busy", 64'(busy16), 64'h0);
                check_val("t1_bubble_grant", 64'(grant16), 64'h0);
            end
            if (c == 24) begin
                check_val("t1_beat_count", 64'(bc16), 64'd20);
                check_val("t1_hold_busy", 64'(busy16), 64'h1);
`ifdef PU_ARB_STATS_EN
                check_val("t1_pu1_count", 64'(pbc16[32 +: 32]), 64'd20);
`endif
            end
            step();
        end

        // Fairness, all PUs valid, BURST_LEN=4
        use4 = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) src_total[i] = 100;
        drive();
        for (int c = 0; c <= 28; c++) begin
            @(negedge clk);
            ep   = (c >= 1 && ((c - 1) % 6) < 4) ? 1 : 0;
            k    = (c - 1) / 6;
            id   = k % 4;
            beat = (k / 4) * 4 + (c - 1) % 6;
            check_cycle("t2", c, ep[0], id, (id << 12) | beat);
            if (c == 5 || c == 6) check_val($sformatf("t2_dead_grant_c%0d", c), 64'(grant4), 64'h0);
            if (c == 28) check_val("t2_beat_count", 64'(bc4), 64'd19);
            step();
        end

        // Early last on PU2's third beat; rr_ptr moves to 3
        use4 = 1'b0;
        do_reset();
        src_total[2] = 3;
        src_last[2]  = 2;
        drive();
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 3)        check_cycle("t3", c, 1'b1, 2, 16'h2000 + c - 1);
            else if (c >= 6 && c <= 7)   check_cycle("t3", c, 1'b1, 3, 16'h3000 + c - 6);
            else if (c >= 10 && c <= 11) check_cycle("t3", c, 1'b1, 0, c - 10);
            else                         check_cycle("t3", c, 1'b0, 0, 0);
            if (c == 4) check_val("t3_release_grant", 64'(grant16), 64'h0);
            if (c == 1) begin
                src_total[0] = 2;  src_last[0] = 1;
                src_total[3] = 2;  src_last[3] = 1;
            end
            step();
        end

        // Backpressure for 5 cycles after beat 7; last coincides with beat 16
        do_reset();
        src_total[1] = 16;
        src_last[1]  = 15;
        drive();
        for (int c = 0; c <= 23; c++) begin
            @(negedge clk);
            ep   = ((c >= 1 && c <= 7) || (c >= 13 && c <= 21)) ? 1 : 0;
            beat = (c <= 7) ? c - 1 : c - 6;
            check_cycle("t4", c, ep[0], 1, 16'h1000 + beat);
            if (c >= 8 && c <= 12) check_val($sformatf("t4_ready_c%0d", c), 64'(b16.req_ready), 64'h0);
            if (c == 22) check_val("t4_release_busy", 64'(busy16), 64'h0);
            if (c == 23) begin
                check_val("t4_beat_count", 64'(bc16), 64'd16);
                check_val("t4_idle_grant", 64'(grant16), 64'h0);
`ifdef PU_ARB_STATS_EN
                check_val("t4_stall_count", 64'(stall16), 64'd5);
                check_val("t4_pu1_count", 64'(pbc16[32 +: 32]), 64'd16);
`endif
            end
            if (c == 7)  full = 1'b1;
            if (c == 12) full = 1'b0;
            step();
        end

        // Async reset at beat 5 of a PU3 burst
        do_reset();
        src_total[3] = 20;
        drive();
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            check_cycle("t5", c, (c >= 1) ? 1'b1 : 1'b0, 3, 16'h3000 + c - 1);
            if (c < 5) step();
        end
        src_total[1] = 5;
        drive();
        #1;
        reset = 1'b0;
        #1;
        check_val("t5_rst_grant", 64'(grant16), 64'h0);
        check_val("t5_rst_busy", 64'(busy16), 64'h0);
        check_val("t5_rst_ready", 64'(b16.req_ready), 64'h0);
        check_val("t5_rst_beats", 64'(bc16), 64'h0);
        check_val("t5_rst_push", 64'(b16.outbuf_push), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_cycle("t5_post", 0, 1'b1, 1, 16'h1000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
